// File: rtl/elec_angle_sincos.sv
// elec_angle_sincos
// Converts a mechanical encoder angle into a zero-offset-corrected electrical
// angle and returns signed Q15 sin/cos of it from a quarter-wave table.
// oDone is a one-cycle strobe for the downstream inverse Park stage. While
// oDone is high, oSin, oCos and oElec_angle already carry the new result.
// They then hold until the next strobe.
//
// The quarter-wave table holds entry k = round(32767*sin(k*pi/2^(ANGLE_BITS-1))).
// It is computed at elaboration with 64-bit fixed-point integer arithmetic,
// so the design does not depend on an external hex image being present.

module elec_angle_sincos #(
  parameter int ENC_BITS   = 14,
  parameter int POLE_PAIRS = 7,
  parameter int ANGLE_BITS = 12
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iEn,
  input  logic [ENC_BITS-1:0]   iMech_angle,
  input  logic [ANGLE_BITS-1:0] iZero_offset,
  output logic [ANGLE_BITS-1:0] oElec_angle,
  output logic signed [15:0]    oSin,
  output logic signed [15:0]    oCos,
  output logic                  oDone,
  output logic                  oBusy,
  output logic                  oOverrun
);

  // Quarter-wave geometry: the table holds QUARTER+1 entries, indices 0..QUARTER.
  localparam int QUARTER  = 1 << (ANGLE_BITS - 2);
  localparam int IDX_BITS = ANGLE_BITS - 1;

  // Fixed-point constants used to build the table (Q30 format).
  localparam longint PI_Q30   = 64'sd3373259426;
  localparam longint HALF_Q30 = 64'sd536870912;
  localparam longint FULL_Q15 = 64'sd32767;

  typedef enum logic [2:0] {
    IDLE,
    SCALE,
    RD_SIN,
    RD_COS,
    OUT
  } stateT;

  stateT state;
  stateT stateNext;

  logic [ENC_BITS-1:0]   mechReg;
  logic [ANGLE_BITS-1:0] offsetReg;
  logic [ANGLE_BITS-1:0] elecReg;
  logic [ENC_BITS-1:0]   mechScaled;
  logic [ANGLE_BITS-1:0] eAngle;
  logic [ANGLE_BITS-1:0] romAngle;
  logic [IDX_BITS-1:0]   romIndex;
  logic                  romNeg;
  logic [14:0]           romWord;
  logic [14:0]           sinMag;
  logic                  sinNeg;
  logic                  overrunReg;

  logic [14:0] romTable [QUARTER+1];

  // round(32767*sin(k*pi/(2*QUARTER))) via a Taylor series in Q30.
  // x never exceeds pi/2, so every product stays within 64 bits.
  function automatic logic [14:0] sinEntry(input int k);
    longint x;
    longint term;
    longint sum;
    longint scaled;
    x    = (longint'(k) * PI_Q30 + longint'(QUARTER)) / longint'(2 * QUARTER);
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    scaled = (sum * FULL_Q15 + HALF_Q30) >>> 30;
    if (scaled < 64'sd0) begin
      scaled = 64'sd0;
    end
    if (scaled > FULL_Q15) begin
      scaled = FULL_Q15;
    end
    return 15'(scaled);
  endfunction

  // Fold a full-circle angle onto the quarter-wave table index.
  // Odd quadrants mirror the index, so k = QUARTER is a legal result.
  function automatic logic [IDX_BITS-1:0] foldIndex(input logic [ANGLE_BITS-1:0] a);
    logic [IDX_BITS-1:0] inQuad;
    inQuad = {1'b0, a[ANGLE_BITS-3:0]};
    if (a[ANGLE_BITS-2]) begin
      return IDX_BITS'(QUARTER) - inQuad;
    end
    return inQuad;
  endfunction

  // Apply the lower-half-circle sign to a table magnitude.
  // A magnitude of zero yields plain zero, and -32768 can never appear.
  function automatic logic signed [15:0] applySign(input logic [14:0] mag, input logic neg);
    logic signed [15:0] wide;
    wide = $signed({1'b0, mag});
    return neg ? -wide : wide;
  endfunction

  // Constant table, one elaboration-time entry per index.
  for (genvar k = 0; k <= QUARTER; k++) begin : genRom
    localparam logic [14:0] ENTRY = sinEntry(k);
    assign romTable[k] = ENTRY;
  end

  // Mechanical-to-electrical scaling: multiply by pole pairs, wrap modulo
  // one mechanical turn, and keep the top ANGLE_BITS bits.
  always_comb begin
    mechScaled = mechReg * ENC_BITS'(POLE_PAIRS);
    eAngle     = ANGLE_BITS'(mechScaled >> (ENC_BITS - ANGLE_BITS));
  end

  // A single table read port is time-shared between the two lookups.
  // RD_SIN looks up the electrical angle itself; RD_COS looks up the
  // angle advanced by a quarter turn.
  always_comb begin
    romAngle = elecReg;
    if (state == RD_COS) begin
      romAngle = elecReg + ANGLE_BITS'(QUARTER);
    end
    romIndex = foldIndex(romAngle);
    romNeg   = romAngle[ANGLE_BITS-1];
    romWord  = romTable[romIndex];
  end

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: a fixed five-state walk, started only from IDLE.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iEn) stateNext = SCALE;
      SCALE:   stateNext = RD_SIN;
      RD_SIN:  stateNext = RD_COS;
      RD_COS:  stateNext = OUT;
      OUT:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Capture the conversion inputs at the moment a start is accepted.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      mechReg   <= '0;
      offsetReg <= '0;
    end else if (state == IDLE && iEn) begin
      mechReg   <= iMech_angle;
      offsetReg <= iZero_offset;
    end
  end

  // Register the offset-corrected electrical angle. Subtraction wraps freely.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      elecReg <= '0;
    end else if (state == SCALE) begin
      elecReg <= eAngle - offsetReg;
    end
  end

  // Synchronous table read for the sin lookup. The magnitude and its sign
  // are held here until the cos lookup completes.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sinMag <= '0;
      sinNeg <= 1'b0;
    end else if (state == RD_SIN) begin
      sinMag <= romWord;
      sinNeg <= romNeg;
    end
  end

  // The cos lookup reads straight into the output register. All three
  // results change on the same edge that enters OUT, so they are valid
  // throughout the oDone cycle and hold otherwise.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oSin        <= '0;
      oCos        <= 16'sd32767;
      oElec_angle <= '0;
    end else if (state == RD_COS) begin
      oSin        <= applySign(sinMag, sinNeg);
      oCos        <= applySign(romWord, romNeg);
      oElec_angle <= elecReg;
    end
  end

  // Sticky flag for a start request that arrives while a conversion is
  // running, including the OUT cycle. Only reset clears it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      overrunReg <= 1'b0;
    end else if (iEn && state != IDLE) begin
      overrunReg <= 1'b1;
    end
  end

  assign oDone    = (state == OUT);
  assign oBusy    = (state != IDLE);
  assign oOverrun = overrunReg;

endmodule

// File: tb/tb_elec_angle_sincos.sv
// Testbench for elec_angle_sincos with default parameters
// (14-bit encoder, 7 pole pairs, 12-bit electrical angle).
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.

module tb_elec_angle_sincos;

  localparam real PI = 3.14159265358979323846;

  logic               iClk = 1'b0;
  logic               iRst_n;
  logic               iEn;
  logic [13:0]        iMech_angle;
  logic [11:0]        iZero_offset;
  logic [11:0]        oElec_angle;
  logic signed [15:0] oSin;
  logic signed [15:0] oCos;
  logic               oDone;
  logic               oBusy;
  logic               oOverrun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [13:0] mech;
    logic [11:0] offset;
    int          expElec;
    int          expSin;
    int          expCos;
  } vecT;

  elec_angle_sincos dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iEn          (iEn),
    .iMech_angle  (iMech_angle),
    .iZero_offset (iZero_offset),
    .oElec_angle  (oElec_angle),
    .oSin         (oSin),
    .oCos         (oCos),
    .oDone        (oDone),
    .oBusy        (oBusy),
    .oOverrun     (oOverrun)
  );

  // 100 MHz clock
  always #5 iClk = ~iClk;

  // Hard stop in case something hangs
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, required completion before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input logic signed [63:0] actual,
                            input longint lo, input longint hi);
    checks++;
    if ($isunknown(actual) || actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Start one conversion with a single-cycle iEn pulse. The task returns
  // the cycle count until oDone is seen (capped at 12) and whether oBusy
  // was high in the first cycle after acceptance.
  task automatic applyStimulus(input logic [13:0] mech, input logic [11:0] offset,
                               output int latency, output logic busyEarly);
    @(negedge iClk);
    iMech_angle  = mech;
    iZero_offset = offset;
    iEn          = 1'b1;
    @(negedge iClk);
    iEn       = 1'b0;
    busyEarly = oBusy;
    latency   = 1;
    while (oDone !== 1'b1 && latency < 12) begin
      @(negedge iClk);
      latency++;
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (oBusy !== 1'b0 && n < 20) begin
      @(negedge iClk);
      n++;
    end
    checkOutput({name, " idle"}, oBusy, 0);
  endtask

  initial begin
    vecT                vecs[13];
    int                 lat;
    logic               busyEarly;
    int                 waited;
    int                 doneCount;
    int                 a;
    int                 sR;
    int                 cR;
    real                sRef;
    real                cRef;
    longint             nrm;
    longint             full;
    logic signed [15:0] capSin;
    logic signed [15:0] capCos;
    logic [11:0]        capElec;

    vecs[0]  = '{"zero",      14'd0,     12'd0,    0,    0,      32767};
    vecs[1]  = '{"deg90",     14'd0,     12'd3072, 1024, 32767,  0};
    vecs[2]  = '{"deg180",    14'd0,     12'd2048, 2048, 0,      -32767};
    vecs[3]  = '{"mechMax",   14'd4681,  12'd0,    4095, -50,    32767};
    vecs[4]  = '{"elecOne",   14'd1,     12'd0,    1,    50,     32767};
    vecs[5]  = '{"offCancel", 14'd1,     12'd1,    0,    0,      32767};
    vecs[6]  = '{"offWrap",   14'd0,     12'd1,    4095, -50,    32767};
    vecs[7]  = '{"deg270",    14'd0,     12'd1024, 3072, -32767, 0};
    vecs[8]  = '{"elec2047",  14'd0,     12'd2049, 2047, 50,     -32767};
    vecs[9]  = '{"modWrap",   14'd2341,  12'd0,    0,    0,      32767};
    vecs[10] = '{"mech16383", 14'd16383, 12'd0,    4094, -101,   32767};
    vecs[11] = '{"deg45",     14'd293,   12'd0,    512,  23170,  23170};
    vecs[12] = '{"deg225",    14'd293,   12'd2048, 2560, -23170, -23170};

    full = 64'sd1073676289;

    // Reset values
    iRst_n       = 1'b0;
    iEn          = 1'b0;
    iMech_angle  = '0;
    iZero_offset = '0;
    repeat (2) @(negedge iClk);
    checkOutput("reset oSin", oSin, 0);
    checkOutput("reset oCos", oCos, 32767);
    checkOutput("reset oElec", oElec_angle, 0);
    checkOutput("reset oDone", oDone, 0);
    checkOutput("reset oBusy", oBusy, 0);
    checkOutput("reset oOverrun", oOverrun, 0);
    iRst_n = 1'b1;
    @(negedge iClk);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].mech, vecs[i].offset, lat, busyEarly);
      checkOutput({vecs[i].name, " latency"}, lat, 4);
      checkOutput({vecs[i].name, " busyEarly"}, busyEarly, 1);
      checkOutput({vecs[i].name, " elec"}, oElec_angle, vecs[i].expElec);
      checkOutput({vecs[i].name, " sin"}, oSin, vecs[i].expSin);
      checkOutput({vecs[i].name, " cos"}, oCos, vecs[i].expCos);
      @(negedge iClk);
      checkOutput({vecs[i].name, " doneOneCycle"}, oDone, 0);
      checkOutput({vecs[i].name, " sinHold"}, oSin, vecs[i].expSin);
      checkOutput({vecs[i].name, " cosHold"}, oCos, vecs[i].expCos);
      checkOutput({vecs[i].name, " busyAfter"}, oBusy, 0);
    end
    checkOutput("table noOverrun", oOverrun, 0);

    // Second start two cycles into a conversion: ignored, flagged as overrun
    @(negedge iClk);
    iMech_angle  = 14'd0;
    iZero_offset = 12'd3072;
    iEn          = 1'b1;
    @(negedge iClk);
    iEn = 1'b0;
    @(negedge iClk);
    iMech_angle  = 14'd4681;
    iZero_offset = 12'd0;
    iEn          = 1'b1;
    @(negedge iClk);
    iEn       = 1'b0;
    doneCount = 0;
    capSin    = '0;
    capCos    = '0;
    capElec   = '0;
    for (int c = 0; c < 12; c++) begin
      if (oDone === 1'b1) begin
        doneCount++;
        if (doneCount == 1) begin
          capSin  = oSin;
          capCos  = oCos;
          capElec = oElec_angle;
        end
      end
      @(negedge iClk);
    end
    checkOutput("overlap doneCount", doneCount, 1);
    checkOutput("overlap elec", capElec, 1024);
    checkOutput("overlap sin", capSin, 32767);
    checkOutput("overlap cos", capCos, 0);
    checkOutput("overlap overrun", oOverrun, 1);
    applyStimulus(14'd1, 12'd0, lat, busyEarly);
    checkOutput("postOverlap latency", lat, 4);
    checkOutput("postOverlap sin", oSin, 50);
    checkOutput("overrun sticky", oOverrun, 1);
    waitIdle("postOverlap");

    // iEn held high: offset sweeps every electrical angle
    @(negedge iClk);
    iMech_angle  = 14'd0;
    iZero_offset = 12'd0;
    iEn          = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      waited = 0;
      do begin
        @(negedge iClk);
        waited++;
      end while (oDone !== 1'b1 && waited < 12);
      checkOutput("sweep interval", waited, (k == 0) ? 4 : 5);
      if (waited >= 12) break;
      a    = (4096 - k) % 4096;
      sRef = 32767.0 * $sin(2.0 * PI * a / 4096.0);
      cRef = 32767.0 * $cos(2.0 * PI * a / 4096.0);
      sR   = $rtoi(sRef + ((sRef >= 0.0) ? 0.5 : -0.5));
      cR   = $rtoi(cRef + ((cRef >= 0.0) ? 0.5 : -0.5));
      checkOutput("sweep elec", oElec_angle, a);
      checkRange("sweep sin", oSin, sR - 1, sR + 1);
      checkRange("sweep cos", oCos, cR - 1, cR + 1);
      checkRange("sweep sinMag", oSin, -32767, 32767);
      checkRange("sweep cosMag", oCos, -32767, 32767);
      nrm = longint'(oSin) * longint'(oSin) + longint'(oCos) * longint'(oCos);
      checkRange("sweep norm", nrm, full - full / 1000, full + full / 1000);
      iZero_offset = 12'(k + 1);
    end
    iEn = 1'b0;
    waitIdle("sweep");
    checkOutput("sweep overrun", oOverrun, 1);

    // Reset asserted during RD_COS
    @(negedge iClk);
    iMech_angle  = 14'd293;
    iZero_offset = 12'd0;
    iEn          = 1'b1;
    @(negedge iClk);
    iEn = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    checkOutput("midReset oSin", oSin, 0);
    checkOutput("midReset oCos", oCos, 32767);
    checkOutput("midReset oElec", oElec_angle, 0);
    checkOutput("midReset oDone", oDone, 0);
    checkOutput("midReset oBusy", oBusy, 0);
    checkOutput("midReset oOverrun", oOverrun, 0);
    @(negedge iClk);
    iRst_n    = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge iClk);
      if (oDone === 1'b1) doneCount++;
    end
    checkOutput("midReset noDone", doneCount, 0);
    applyStimulus(14'd1, 12'd0, lat, busyEarly);
    checkOutput("afterReset latency", lat, 4);
    checkOutput("afterReset elec", oElec_angle, 1);
    checkOutput("afterReset sin", oSin, 50);
    checkOutput("afterReset cos", oCos, 32767);
    checkOutput("afterReset overrun", oOverrun, 0);
    waitIdle("afterReset");

    // Start request during the OUT cycle: counts as overrun, not accepted
    applyStimulus(14'd0, 12'd0, lat, busyEarly);
    checkOutput("outCycle latency", lat, 4);
    iMech_angle = 14'd4681;
    iEn         = 1'b1;
    @(negedge iClk);
    iEn = 1'b0;
    checkOutput("outCycle notAccepted", oBusy, 0);
    checkOutput("outCycle overrun", oOverrun, 1);
    doneCount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge iClk);
      if (oDone === 1'b1) doneCount++;
    end
    checkOutput("outCycle noExtraDone", doneCount, 0);
    checkOutput("outCycle elecHeld", oElec_angle, 0);
    checkOutput("outCycle cosHeld", oCos, 32767);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
